fat32_sector_scheduler: RTL and testbench

- Sequences the SD sector layer for FAT32 file writes: reads sector 0 of the partition, parses the BPB, derives the FAT, data and root-directory sector addresses, then issues consecutive data-sector writes as the upstream buffer fills.
- Sits between the sector buffer/file logic and the SD block read/write engine.
- Sole owner of sd_rd_req, sd_wr_req and sd_addr.

---
 rtl/fat32_sector_scheduler.sv | 177 +++++++++++++++++
 tb/tb_fat32_sector_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fat32_sector_scheduler.sv
// FAT32 sector sequencer: reads and validates the partition BPB, derives the FAT/data/root
// addresses, then streams consecutive data-sector writes as upstream sectors become ready.
module fat32_sector_scheduler #(
    parameter logic [31:0] PARTITION_LBA = 32'd0,
    parameter logic [31:0] START_CLUSTER = 32'd3,
    parameter logic [31:0] MAX_SECTORS   = 32'd65536
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    output logic        sd_rd_req,
    output logic        sd_wr_req,
    output logic [31:0] sd_addr,
    input  logic        sd_ack,
    input  logic        rd_byte_valid,
    input  logic [7:0]  rd_byte,
    input  logic        buf_ready,
    output logic        buf_release,
    output logic        ready,
    output logic        busy,
    output logic        error,
    output logic        full,
    output logic [31:0] root_dir_sector,
    output logic [31:0] sectors_written
);

    typedef enum logic [2:0] {
        StIdle, StRdBpb, StCalc1, StCalc2, StReady, StWr, StFull, StError
    } state_e;

    state_e      state_q;
    logic [8:0]  byte_cnt_q;
    logic        cnt_done_q, cnt_ovf_q;
    logic [15:0] bps_q, rsvd_q;
    logic [7:0]  spc_q, nfat_q, sig0_q, sig1_q;
    logic [31:0] fatsz_q, root_clus_q, fat_begin_q, fat_total_q, wr_addr_q;
    logic [31:0] sd_addr_q, root_dir_q, sec_wr_q;
    logic        rd_req_q, wr_req_q, buf_release_q;
    logic        ready_q, busy_q, error_q, full_q;

    logic        bpb_bad;
    logic [31:0] data_begin, spc_ext;

    assign spc_ext    = {24'd0, spc_q};
    assign data_begin = fat_begin_q + fat_total_q;
    // cnt_done_q marks byte 511 seen; any byte after that sets cnt_ovf_q.
    assign bpb_bad = !cnt_done_q || cnt_ovf_q || (bps_q != 16'd512) ||
                     (sig0_q != 8'h55) || (sig1_q != 8'hAA) ||
                     (spc_q == 8'd0) || (nfat_q == 8'd0) || (root_clus_q < 32'd2);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q       <= StIdle;
            byte_cnt_q    <= 9'd0;
            cnt_done_q    <= 1'b0;
            cnt_ovf_q     <= 1'b0;
            bps_q         <= 16'd0;
            rsvd_q        <= 16'd0;
            spc_q         <= 8'd0;
            nfat_q        <= 8'd0;
            sig0_q        <= 8'd0;
            sig1_q        <= 8'd0;
            fatsz_q       <= 32'd0;
            root_clus_q   <= 32'd0;
            fat_begin_q   <= 32'd0;
            fat_total_q   <= 32'd0;
            wr_addr_q     <= 32'd0;
            sd_addr_q     <= 32'd0;
            root_dir_q    <= 32'd0;
            sec_wr_q      <= 32'd0;
            rd_req_q      <= 1'b0;
            wr_req_q      <= 1'b0;
            buf_release_q <= 1'b0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
            full_q        <= 1'b0;
        end else begin
            buf_release_q <= 1'b0;
            ready_q       <= (state_q == StReady);
            busy_q        <= state_q inside {StRdBpb, StCalc1, StCalc2, StWr};
            error_q       <= (state_q == StError);
            full_q        <= (state_q == StFull);

            unique case (state_q)
                StIdle, StError, StFull: begin
                    if (start) begin
                        state_q    <= StRdBpb;
                        sec_wr_q   <= 32'd0;
                        byte_cnt_q <= 9'd0;
                        cnt_done_q <= 1'b0;
                        cnt_ovf_q  <= 1'b0;
                        sd_addr_q  <= PARTITION_LBA;
                        rd_req_q   <= 1'b1;
                    end
                end
                StRdBpb: begin
                    if (rd_byte_valid) begin
                        if (cnt_done_q) begin
                            cnt_ovf_q <= 1'b1;
                        end else begin
                            case (byte_cnt_q)
                                9'h00B:  bps_q[7:0]          <= rd_byte;
                                9'h00C:  bps_q[15:8]         <= rd_byte;
                                9'h00D:  spc_q               <= rd_byte;
                                9'h00E:  rsvd_q[7:0]         <= rd_byte;
                                9'h00F:  rsvd_q[15:8]        <= rd_byte;
                                9'h010:  nfat_q              <= rd_byte;
                                9'h024:  fatsz_q[7:0]        <= rd_byte;
                                9'h025:  fatsz_q[15:8]       <= rd_byte;
                                9'h026:  fatsz_q[23:16]      <= rd_byte;
                                9'h027:  fatsz_q[31:24]      <= rd_byte;
                                9'h02C:  root_clus_q[7:0]    <= rd_byte;
                                9'h02D:  root_clus_q[15:8]   <= rd_byte;
                                9'h02E:  root_clus_q[23:16]  <= rd_byte;
                                9'h02F:  root_clus_q[31:24]  <= rd_byte;
                                9'h1FE:  sig0_q              <= rd_byte;
                                9'h1FF:  sig1_q              <= rd_byte;
                                default: ;
                            endcase
                            byte_cnt_q <= byte_cnt_q + 9'd1;
                            if (byte_cnt_q == 9'h1FF) cnt_done_q <= 1'b1;
                        end
                    end
                    if (sd_ack) begin
                        rd_req_q <= 1'b0;
                        state_q  <= bpb_bad ? StError : StCalc1;
                    end
                end
                StCalc1: begin
                    fat_begin_q <= PARTITION_LBA + {16'd0, rsvd_q};
                    fat_total_q <= {24'd0, nfat_q} * fatsz_q;
                    state_q     <= StCalc2;
                end
                StCalc2: begin
                    root_dir_q <= data_begin + (root_clus_q - 32'd2) * spc_ext;
                    wr_addr_q  <= data_begin + (START_CLUSTER - 32'd2) * spc_ext;
                    state_q    <= StReady;
                end
                StReady: begin
                    // Skip the release cycle so upstream has a full cycle to drop buf_ready.
                    if (buf_ready && !buf_release_q) begin
                        if (sec_wr_q == MAX_SECTORS) begin
                            state_q <= StFull;
                        end else begin
                            state_q   <= StWr;
                            sd_addr_q <= wr_addr_q;
                            wr_req_q  <= 1'b1;
                        end
                    end
                end
                StWr: begin
                    if (sd_ack) begin
                        wr_req_q      <= 1'b0;
                        buf_release_q <= 1'b1;
                        sec_wr_q      <= sec_wr_q + 32'd1;
                        wr_addr_q     <= wr_addr_q + 32'd1;
                        state_q       <= StReady;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sd_rd_req       = rd_req_q;
    assign sd_wr_req       = wr_req_q;
    assign sd_addr         = sd_addr_q;
    assign buf_release     = buf_release_q;
    assign ready           = ready_q;
    assign busy            = busy_q;
    assign error           = error_q;
    assign full            = full_q;
    assign root_dir_sector = root_dir_q;
    assign sectors_written = sec_wr_q;

endmodule

// File: tb/tb_fat32_sector_scheduler.sv
// Directed bench for fat32_sector_scheduler: two instances share stimulus, one with default
// parameters and one with PARTITION_LBA=100, MAX_SECTORS=2.
module tb_fat32_sector_scheduler;

    logic        clk = 1'b0;
    logic        rst_n, start, sd_ack, rd_byte_valid, buf_ready;
    logic [7:0]  rd_byte;
    logic        a_rd, a_wr, a_rel, a_ready, a_busy, a_error, a_full;
    logic [31:0] a_addr, a_root, a_sw;
    logic        b_rd, b_wr, b_rel, b_ready, b_busy, b_error, b_full;
    logic [31:0] b_addr, b_root, b_sw;
    logic [7:0]  img [512];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fat32_sector_scheduler dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .sd_rd_req(a_rd), .sd_wr_req(a_wr),
        .sd_addr(a_addr), .sd_ack(sd_ack), .rd_byte_valid(rd_byte_valid), .rd_byte(rd_byte),
        .buf_ready(buf_ready), .buf_release(a_rel), .ready(a_ready), .busy(a_busy),
        .error(a_error), .full(a_full), .root_dir_sector(a_root), .sectors_written(a_sw)
    );

    fat32_sector_scheduler #(
        .PARTITION_LBA(32'd100), .START_CLUSTER(32'd3), .MAX_SECTORS(32'd2)
    ) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .sd_rd_req(b_rd), .sd_wr_req(b_wr),
        .sd_addr(b_addr), .sd_ack(sd_ack), .rd_byte_valid(rd_byte_valid), .rd_byte(rd_byte),
        .buf_ready(buf_ready), .buf_release(b_rel), .ready(b_ready), .busy(b_busy),
        .error(b_error), .full(b_full), .root_dir_sector(b_root), .sectors_written(b_sw)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic build_img(input logic [15:0] bps, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] rc);
        for (int i = 0; i < 512; i++) img[i] = 8'h00;
        img[11] = bps[7:0];  img[12] = bps[15:8];
        img[13] = 8'd8;      img[14] = 8'd32;     img[15] = 8'd0;  img[16] = 8'd2;
        img[36] = 8'hE8;     img[37] = 8'h03;                         // fatsz = 1000
        img[44] = rc;
        img[510] = s0;       img[511] = s1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_ack;
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
    endtask

    // start, stream nbytes of img, then ack; returns one cycle after the ack edge
    task automatic run_bpb(input logic [15:0] bps, input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] rc, input int nbytes);
        build_img(bps, s0, s1, rc);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (a_rd !== 1'b1 || a_addr !== 32'd0 || a_wr !== 1'b0) begin
            errors++;
            $display("FAIL start_rd_a: rd=%b addr=%0d wr=%b want rd=1 addr=0 wr=0",
                     a_rd, a_addr, a_wr);
        end
        checks++;
        if (b_rd !== 1'b1 || b_addr !== 32'd100) begin
            errors++;
            $display("FAIL start_rd_b: rd=%b addr=%0d want rd=1 addr=100", b_rd, b_addr);
        end
        for (int i = 0; i < nbytes; i++) begin
            rd_byte_valid = 1'b1;
            rd_byte = img[i % 512];
            tick();
        end
        rd_byte_valid = 1'b0;
        rd_byte = 8'h00;
        pulse_ack();
        checks++;
        if (a_rd !== 1'b0) begin
            errors++;
            $display("FAIL rd_drop: sd_rd_req=%b want 0", a_rd);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({a_rd, a_wr, a_rel, a_ready, a_busy, a_error, a_full} !== 7'd0 ||
            a_addr !== 32'd0 || a_root !== 32'd0 || a_sw !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: flags=%b addr=%0d root=%0d sw=%0d want all 0",
                     {a_rd, a_wr, a_rel, a_ready, a_busy, a_error, a_full}, a_addr, a_root, a_sw);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_valid_bpb;
        run_bpb(16'd512, 8'h55, 8'hAA, 8'd2, 512);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (a_ready !== 1'b0 || a_busy !== 1'b1) begin
                errors++;
                $display("FAIL calc_phase%0d: ready=%b busy=%b want 0/1", c, a_ready, a_busy);
            end
            tick();
        end
        checks++;
        if (a_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_early: ready=%b want 0 two cycles after ack", a_ready);
        end
        tick();
        checks++;
        if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_error !== 1'b0) begin
            errors++;
            $display("FAIL ready_rise: ready=%b busy=%b error=%b want 1/0/0",
                     a_ready, a_busy, a_error);
        end
        checks++;
        if (a_root !== 32'd2032 || b_root !== 32'd2132) begin
            errors++;
            $display("FAIL root_dir: a=%0d b=%0d want 2032/2132", a_root, b_root);
        end
    endtask

    task automatic test_back_to_back;
        logic seen;
        buf_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                if (a_wr === 1'b1) seen = 1'b1;
                else tick();
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL wr_req%0d: sd_wr_req=0 after 10 cycles, want 1", w);
            end
            checks++;
            if (a_addr !== 32'd2040 + w || a_rd !== 1'b0) begin
                errors++;
                $display("FAIL wr_addr%0d: addr=%0d rd=%b want %0d rd=0", w, a_addr, a_rd, 2040 + w);
            end
            checks++;
            if (w < 2 && (b_wr !== 1'b1 || b_addr !== 32'd2140 + w)) begin
                errors++;
                $display("FAIL wr_b%0d: wr=%b addr=%0d want 1 %0d", w, b_wr, b_addr, 2140 + w);
            end else if (w == 2 && b_wr !== 1'b0) begin
                errors++;
                $display("FAIL no_third_wr_b: sd_wr_req=%b want 0", b_wr);
            end
            pulse_ack();
            if (w == 2) buf_ready = 1'b0;
            checks++;
            if (a_rel !== 1'b1 || a_wr !== 1'b0 || a_sw !== 32'd1 + w) begin
                errors++;
                $display("FAIL release%0d: rel=%b wr=%b sw=%0d want 1 0 %0d",
                         w, a_rel, a_wr, a_sw, w + 1);
            end
            tick();
            checks++;
            if (a_rel !== 1'b0) begin
                errors++;
                $display("FAIL release_pulse%0d: buf_release=%b want 0", w, a_rel);
            end
        end
        tick();
        tick();
        checks++;
        if (b_full !== 1'b1 || b_sw !== 32'd2 || a_sw !== 32'd3 || a_full !== 1'b0) begin
            errors++;
            $display("FAIL full: b_full=%b b_sw=%0d a_sw=%0d a_full=%b want 1 2 3 0",
                     b_full, b_sw, a_sw, a_full);
        end
    endtask

    task automatic test_reset_mid_write;
        logic seen;
        buf_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (a_wr === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_wr_req: sd_wr_req=0 after 10 cycles, want 1");
        end
        buf_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({a_rd, a_wr, a_rel, a_ready, a_busy, a_error, a_full, b_full} !== 8'd0 ||
            a_addr !== 32'd0 || a_root !== 32'd0 || a_sw !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: flags=%b addr=%0d root=%0d sw=%0d want all 0",
                     {a_rd, a_wr, a_rel, a_ready, a_busy, a_error, a_full, b_full},
                     a_addr, a_root, a_sw);
        end
        rst_n = 1'b1;
        pulse_ack();
        tick();
        checks++;
        if (a_sw !== 32'd0 || a_rel !== 1'b0 || a_wr !== 1'b0 || a_busy !== 1'b0 ||
            a_ready !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: sw=%0d rel=%b wr=%b busy=%b ready=%b want all 0",
                     a_sw, a_rel, a_wr, a_busy, a_ready);
        end
    endtask

    // Drives a bad BPB, then holds buf_ready to confirm no write is ever requested.
    task automatic check_bad(input string name, input logic [15:0] bps, input logic [7:0] s1,
                             input int nbytes);
        logic wr_seen;
        run_bpb(bps, 8'h55, s1, 8'd2, nbytes);
        buf_ready = 1'b1;
        wr_seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (a_wr !== 1'b0 || b_wr !== 1'b0) wr_seen = 1'b1;
        end
        buf_ready = 1'b0;
        checks++;
        if (a_error !== 1'b1 || b_error !== 1'b1 || wr_seen !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: error=%b/%b wr_seen=%b busy=%b want 1/1 0 0",
                     name, a_error, b_error, wr_seen, a_busy);
        end
    endtask

    task automatic test_errors;
        check_bad("bad_sig", 16'd512, 8'h00, 512);
        run_bpb(16'd512, 8'h55, 8'hAA, 8'd5, 512);
        tick();
        tick();
        tick();
        checks++;
        if (a_ready !== 1'b1 || a_error !== 1'b0 || a_root !== 32'd2056 || b_root !== 32'd2156) begin
            errors++;
            $display("FAIL recover: ready=%b error=%b root=%0d/%0d want 1 0 2056/2156",
                     a_ready, a_error, a_root, b_root);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (a_rd !== 1'b0 || a_ready !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_ready: rd=%b ready=%b busy=%b want 0 1 0",
                     a_rd, a_ready, a_busy);
        end
        do_reset();
        check_bad("bps_1024", 16'd1024, 8'hAA, 512);
        check_bad("short_300", 16'd512, 8'hAA, 300);
        check_bad("extra_513", 16'd512, 8'hAA, 513);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sd_ack = 1'b0;
        rd_byte_valid = 1'b0;
        rd_byte = 8'h00;
        buf_ready = 1'b0;
        test_reset();
        test_valid_bpb();
        test_back_to_back();
        test_reset_mid_write();
        test_errors();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
